llsc_mem_ctrl: RTL and testbench

LLSC_MEM_CTRL -- requirements
Module: llsc_mem_ctrl

---
 rtl/llsc_mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_llsc_mem_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llsc_mem_ctrl.sv
// LL/SC link controller for the MEM stage.
// Tracks the word-aligned link address, decides SC success from the
// (forwarded) LLbit and an address match, gates the data-memory store
// enable accordingly, and produces a one-cycle-delayed LLbit write for
// the architectural LLbit register.
module llsc_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall,
  input  logic        flush,
  input  logic        is_ll,
  input  logic        is_sc,
  input  logic        is_store,
  input  logic        is_eret,
  input  logic [31:0] mem_addr_i,
  input  logic        LLbit_rdata,
  output logic        mem_we_o,
  output logic [31:0] sc_result_o,
  output logic        LLbit_we_o,
  output logic        LLbit_wdata_o,
  output logic [31:0] link_addr_o
);

  // Resolved MEM-stage operation after qualification and priority decode.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_ERET  = 3'd1,
    OP_SC    = 3'd2,
    OP_LL    = 3'd3,
    OP_STORE = 3'd4
  } op_kind_e;

  // Word-aligned form of an effective address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    word_align = {addr[31:2], 2'b00};
  endfunction

  // Registered state: link address and the pending LLbit write.
  logic [31:0] link_addr_q, link_addr_d;
  logic        llbit_we_q, llbit_we_d;
  logic        llbit_wdata_q, llbit_wdata_d;

  // Combinational MEM-stage signals.
  logic        op_ok_s;
  logic        eff_llbit_s;
  logic        word_hit_s;
  logic        sc_success_s;
  logic        mem_we_s;
  logic [31:0] sc_result_s;
  op_kind_e    op_kind_s;

  // Byte-offset bits do not participate in the word match.
  logic        unused_addr_bits_s;
  assign unused_addr_bits_s = ^mem_addr_i[1:0];

  // Reset also kills the op so that no store or SC result escapes while rst=1.
  assign op_ok_s = valid_i & ~stall & ~flush & ~rst;

  // A write already sitting in the WB register is newer than the LLbit
  // register contents, so forward it for back-to-back LL/SC/store.
  assign eff_llbit_s = llbit_we_q ? llbit_wdata_q : LLbit_rdata;

  assign word_hit_s   = (mem_addr_i[31:2] == link_addr_q[31:2]);
  assign sc_success_s = eff_llbit_s & word_hit_s;

  // Priority decode of the qualified op: eret > sc > ll > store.
  always_comb begin
    op_kind_s = OP_NONE;
    if (!op_ok_s) begin
      op_kind_s = OP_NONE;
    end else if (is_eret) begin
      op_kind_s = OP_ERET;
    end else if (is_sc) begin
      op_kind_s = OP_SC;
    end else if (is_ll) begin
      op_kind_s = OP_LL;
    end else if (is_store) begin
      op_kind_s = OP_STORE;
    end else begin
      op_kind_s = OP_NONE;
    end
  end

  // Per-op effects: same-cycle store gating / SC result, and next-state
  // for the link address and the WB LLbit write (bubble by default).
  always_comb begin
    mem_we_s      = 1'b0;
    sc_result_s   = 32'h0000_0000;
    llbit_we_d    = 1'b0;
    llbit_wdata_d = 1'b0;
    link_addr_d   = link_addr_q;
    case (op_kind_s)
      OP_ERET: begin
        llbit_we_d    = 1'b1;
        llbit_wdata_d = 1'b0;
      end
      OP_SC: begin
        mem_we_s      = sc_success_s;
        sc_result_s   = {31'b0, sc_success_s};
        llbit_we_d    = 1'b1;
        llbit_wdata_d = 1'b0;
      end
      OP_LL: begin
        link_addr_d   = word_align(mem_addr_i);
        llbit_we_d    = 1'b1;
        llbit_wdata_d = 1'b1;
      end
      OP_STORE: begin
        mem_we_s = 1'b1;
        // An ordinary store to the linked word breaks the reservation.
        if (word_hit_s && eff_llbit_s) begin
          llbit_we_d    = 1'b1;
          llbit_wdata_d = 1'b0;
        end else begin
          llbit_we_d    = 1'b0;
          llbit_wdata_d = 1'b0;
        end
      end
      OP_NONE: begin
        llbit_we_d    = 1'b0;
        llbit_wdata_d = 1'b0;
      end
      default: begin
        mem_we_s      = 1'b0;
        sc_result_s   = 32'h0000_0000;
        llbit_we_d    = 1'b0;
        llbit_wdata_d = 1'b0;
        link_addr_d   = link_addr_q;
      end
    endcase
  end

  // State update; reset clears the link and discards any pending LLbit write.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_addr_q   <= 32'h0000_0000;
      llbit_we_q    <= 1'b0;
      llbit_wdata_q <= 1'b0;
    end else begin
      link_addr_q   <= link_addr_d;
      llbit_we_q    <= llbit_we_d;
      llbit_wdata_q <= llbit_wdata_d;
    end
  end

  assign mem_we_o      = mem_we_s;
  assign sc_result_o   = sc_result_s;
  assign LLbit_we_o    = llbit_we_q;
  assign LLbit_wdata_o = llbit_wdata_q;
  assign link_addr_o   = link_addr_q;

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
// Directed self-checking bench for llsc_mem_ctrl. A simple LLbit register
// is modelled here so that committed LLbit values feed back into the DUT.
module tb_llsc_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        stall;
  logic        flush;
  logic        is_ll;
  logic        is_sc;
  logic        is_store;
  logic        is_eret;
  logic [31:0] mem_addr_i;
  logic        LLbit_rdata;
  logic        mem_we_o;
  logic [31:0] sc_result_o;
  logic        LLbit_we_o;
  logic        LLbit_wdata_o;
  logic [31:0] link_addr_o;

  int n_checks;
  int n_fail;

  llsc_mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .stall        (stall),
    .flush        (flush),
    .is_ll        (is_ll),
    .is_sc        (is_sc),
    .is_store     (is_store),
    .is_eret      (is_eret),
    .mem_addr_i   (mem_addr_i),
    .LLbit_rdata  (LLbit_rdata),
    .mem_we_o     (mem_we_o),
    .sc_result_o  (sc_result_o),
    .LLbit_we_o   (LLbit_we_o),
    .LLbit_wdata_o(LLbit_wdata_o),
    .link_addr_o  (link_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External LLbit register: commits the WB write on each edge.
  logic llbit_reg;
  always @(posedge clk) begin
    if (rst) llbit_reg <= 1'b0;
    else if (LLbit_we_o) llbit_reg <= LLbit_wdata_o;
  end
  assign LLbit_rdata = llbit_reg;

  // Advance past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ll, input logic sc, input logic st,
                        input logic er, input logic [31:0] addr);
    valid_i = 1'b1; stall = 1'b0; flush = 1'b0;
    is_ll = ll; is_sc = sc; is_store = st; is_eret = er;
    mem_addr_i = addr;
    #2;
  endtask

  task automatic set_idle();
    valid_i = 1'b0; stall = 1'b0; flush = 1'b0;
    is_ll = 1'b0; is_sc = 1'b0; is_store = 1'b0; is_eret = 1'b0;
    mem_addr_i = 32'h0;
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
    n_checks++;
    if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we_o); end
    step(); step();
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
    n_checks++;
    if (sc_result_o !== 32'h0) begin n_fail++; $display("FAIL reset_sc_result: got %h want 0", sc_result_o); end
    n_checks++;
    if (LLbit_we_o !== 1'b0 || LLbit_wdata_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_llbit: got we=%b wd=%b want 0/0", LLbit_we_o, LLbit_wdata_o);
    end
    n_checks++;
    if (link_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_link: got %h want 0", link_addr_o); end
    set_idle();
    rst = 1'b0;
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_we: got %b want 0", LLbit_we_o); end
  endtask

  task automatic test_ll_sc_forward();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1002);
    n_checks++;
    if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL ll_mem_we: got %b want 0", mem_we_o); end
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b1 || LLbit_wdata_o !== 1'b1) begin
      n_fail++; $display("FAIL ll_wb: got we=%b wd=%b want 1/1", LLbit_we_o, LLbit_wdata_o);
    end
    n_checks++;
    if (link_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL ll_link: got %h want 00001000", link_addr_o); end
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000);
    n_checks++;
    if (mem_we_o !== 1'b1) begin n_fail++; $display("FAIL sc_fwd_mem_we: got %b want 1", mem_we_o); end
    n_checks++;
    if (sc_result_o !== 32'h1) begin n_fail++; $display("FAIL sc_fwd_result: got %h want 1", sc_result_o); end
    step();
    set_idle();
    n_checks++;
    if (LLbit_we_o !== 1'b1 || LLbit_wdata_o !== 1'b0) begin
      n_fail++; $display("FAIL sc_wb: got we=%b wd=%b want 1/0", LLbit_we_o, LLbit_wdata_o);
    end
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b0) begin n_fail++; $display("FAIL idle_bubble: got %b want 0", LLbit_we_o); end
  endtask

  task automatic test_sc_miss();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000);
    step();
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1004);
    n_checks++;
    if (mem_we_o !== 1'b0 || sc_result_o !== 32'h0) begin
      n_fail++; $display("FAIL sc_miss: got we=%b res=%h want 0/0", mem_we_o, sc_result_o);
    end
    step();
    set_idle();
    n_checks++;
    if (link_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL sc_miss_link: got %h want 00001000", link_addr_o); end
    n_checks++;
    if (LLbit_we_o !== 1'b1 || LLbit_wdata_o !== 1'b0) begin
      n_fail++; $display("FAIL sc_miss_wb: got we=%b wd=%b want 1/0", LLbit_we_o, LLbit_wdata_o);
    end
    step();
  endtask

  task automatic test_store_clears();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000);
    step();
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2002);
    n_checks++;
    if (mem_we_o !== 1'b1) begin n_fail++; $display("FAIL sw_hit_mem_we: got %b want 1", mem_we_o); end
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b1 || LLbit_wdata_o !== 1'b0) begin
      n_fail++; $display("FAIL sw_hit_wb: got we=%b wd=%b want 1/0", LLbit_we_o, LLbit_wdata_o);
    end
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2000);
    n_checks++;
    if (sc_result_o !== 32'h0 || mem_we_o !== 1'b0) begin
      n_fail++; $display("FAIL sc_after_sw: got res=%h we=%b want 0/0", sc_result_o, mem_we_o);
    end
    step();
    set_idle();
    step();
  endtask

  task automatic test_store_miss();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000);
    step();
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2008);
    n_checks++;
    if (mem_we_o !== 1'b1) begin n_fail++; $display("FAIL sw_miss_mem_we: got %b want 1", mem_we_o); end
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b0) begin n_fail++; $display("FAIL sw_miss_wb: got %b want 0", LLbit_we_o); end
    // LLbit now comes from the committed register, not forwarding.
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2000);
    n_checks++;
    if (mem_we_o !== 1'b1 || sc_result_o !== 32'h1) begin
      n_fail++; $display("FAIL sc_committed: got we=%b res=%h want 1/1", mem_we_o, sc_result_o);
    end
    step();
    set_idle();
    step();
  endtask

  task automatic test_eret();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000);
    step();
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b1 || LLbit_wdata_o !== 1'b0) begin
      n_fail++; $display("FAIL eret_wb: got we=%b wd=%b want 1/0", LLbit_we_o, LLbit_wdata_o);
    end
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3000);
    n_checks++;
    if (mem_we_o !== 1'b0 || sc_result_o !== 32'h0) begin
      n_fail++; $display("FAIL sc_after_eret: got we=%b res=%h want 0/0", mem_we_o, sc_result_o);
    end
    step();
    set_idle();
    step();
  endtask

  task automatic test_flush_stall();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000);
    step();
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000);
    flush = 1'b1;
    #1;
    n_checks++;
    if (mem_we_o !== 1'b0 || sc_result_o !== 32'h0) begin
      n_fail++; $display("FAIL sc_flush: got we=%b res=%h want 0/0", mem_we_o, sc_result_o);
    end
    n_checks++;
    if (LLbit_we_o !== 1'b1) begin n_fail++; $display("FAIL flush_wb_kept: got %b want 1", LLbit_we_o); end
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b0 || link_addr_o !== 32'h0000_1000) begin
      n_fail++; $display("FAIL sc_flush_after: got we=%b link=%h want 0/00001000", LLbit_we_o, link_addr_o);
    end
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000);
    stall = 1'b1;
    #1;
    n_checks++;
    if (mem_we_o !== 1'b0 || sc_result_o !== 32'h0) begin
      n_fail++; $display("FAIL sc_stall: got we=%b res=%h want 0/0", mem_we_o, sc_result_o);
    end
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b0 || link_addr_o !== 32'h0000_1000) begin
      n_fail++; $display("FAIL sc_stall_after: got we=%b link=%h want 0/00001000", LLbit_we_o, link_addr_o);
    end
    // A flushed LL must not move the link address.
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_7000);
    flush = 1'b1;
    step();
    n_checks++;
    if (link_addr_o !== 32'h0000_1000 || LLbit_we_o !== 1'b0) begin
      n_fail++; $display("FAIL ll_flush: got link=%h we=%b want 00001000/0", link_addr_o, LLbit_we_o);
    end
    set_idle();
    step();
  endtask

  task automatic test_priority();
    // LL 0x1000 committed above; sc+ll together must act as SC at 0x5000.
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_5000);
    n_checks++;
    if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL prio_sc_ll_we: got %b want 0", mem_we_o); end
    step();
    n_checks++;
    if (link_addr_o !== 32'h0000_1000 || LLbit_wdata_o !== 1'b0) begin
      n_fail++; $display("FAIL prio_sc_ll: got link=%h wd=%b want 00001000/0", link_addr_o, LLbit_wdata_o);
    end
    set_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_5000);
    n_checks++;
    if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL prio_eret_st: got %b want 0", mem_we_o); end
    step();
    set_idle();
    step();
  endtask

  task automatic test_reset_after_ll();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4000);
    step();
    rst = 1'b1;
    set_idle();
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b0 || link_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_after_ll: got we=%b link=%h want 0/0", LLbit_we_o, link_addr_o);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (LLbit_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_release_we: got %b want 0", LLbit_we_o); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    valid_i = 1'b0; stall = 1'b0; flush = 1'b0;
    is_ll = 1'b0; is_sc = 1'b0; is_store = 1'b0; is_eret = 1'b0;
    mem_addr_i = 32'h0;
    test_reset();
    test_ll_sc_forward();
    test_sc_miss();
    test_store_clears();
    test_store_miss();
    test_eret();
    test_flush_stall();
    test_priority();
    test_reset_after_ll();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
